// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-32 control unit.
// Optional performance counters are enabled with MIPS_MC_PERF_CNT_EN.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd15
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_ALU = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
        logic       retire;
        logic       trap;
    } ctl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct field to ALU operation decode, flagging unsupported functs.
module mips_alu_dec
    import mips_pkg::*;
#(
    parameter int FNW = 6
) (
    input  logic [FNW-1:0] funct,
    output logic [3:0]     alu_ctl,
    output logic           illegal
);

    always_comb begin
        alu_ctl = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FNW'(FN_ADD): alu_ctl = ALU_ADD;
            FNW'(FN_SUB): alu_ctl = ALU_SUB;
            FNW'(FN_AND): alu_ctl = ALU_AND;
            FNW'(FN_OR):  alu_ctl = ALU_OR;
            FNW'(FN_SLT): alu_ctl = ALU_SLT;
            default:      illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS-32 control FSM with memory-wait timeout trap.
// Define MIPS_MC_PERF_CNT_EN to add cycle/instruction counters.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int FNW     = 6,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic [FNW-1:0]  funct,
    input  logic            alu_zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            ir_write,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [3:0]      alu_ctl,
    output logic            retire,
    output logic            trap,
`ifdef MIPS_MC_PERF_CNT_EN
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ins_cnt,
`endif
    output logic [3:0]      state_o
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e        state_q, state_d;
    logic [TW-1:0] wait_q, wait_d;
    ctl_t          ctl, ctl_o;
    logic          waiting;
    logic [3:0]    fn_alu_ctl;
    logic          fn_illegal;

    mips_alu_dec #(.FNW(FNW)) u_alu_dec (
        .funct   (funct),
        .alu_ctl (fn_alu_ctl),
        .illegal (fn_illegal)
    );

    always_comb begin
        ctl     = '0;
        state_d = state_q;
        waiting = 1'b0;
        wait_d  = wait_q;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_4;
                ctl.alu_ctl   = ALU_ADD;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = PC_ALU;
                    state_d      = S_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH;
                ctl.alu_ctl   = ALU_ADD;
                case (opcode)
                    OPW'(OP_R):    state_d = S_EXEC_R;
                    OPW'(OP_LW),
                    OPW'(OP_SW),
                    OPW'(OP_ADDI): state_d = S_EXEC_I;
                    OPW'(OP_BEQ):  state_d = S_BRANCH;
                    OPW'(OP_J):    state_d = S_JUMP;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_RT;
                ctl.alu_ctl   = fn_alu_ctl;
                state_d       = fn_illegal ? S_TRAP : S_WB_R;
            end
            S_WB_R: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                ctl.retire    = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_ctl   = ALU_ADD;
                case (opcode)
                    OPW'(OP_LW): state_d = S_MEM_RD;
                    OPW'(OP_SW): state_d = S_MEM_WR;
                    default:     state_d = S_WB_I;
                endcase
            end
            S_WB_I: begin
                ctl.reg_write = 1'b1;
                ctl.retire    = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_RD: begin
                ctl.iord     = 1'b1;
                ctl.mem_read = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
                else           waiting = 1'b1;
            end
            S_WB_MEM: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.retire     = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WR: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
                if (mem_ready) begin
                    ctl.retire = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_RT;
                ctl.alu_ctl   = ALU_SUB;
                ctl.pc_src    = PC_BR;
                ctl.pc_write  = alu_zero;
                ctl.retire    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_src   = PC_JMP;
                ctl.pc_write = 1'b1;
                ctl.retire   = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: ctl.trap = 1'b1;
            default: state_d = S_TRAP;
        endcase
        // The timeout fires on the edge that completes TIMEOUT waiting cycles;
        // a ready in that cycle leaves waiting low, so it always wins.
        if (waiting) begin
            wait_d = wait_q + 1'b1;
            if (TIMEOUT > 0 && wait_d == TW'(TIMEOUT)) state_d = S_TRAP;
        end
        if (state_d != state_q) wait_d = '0;
        ctl_o = rst ? '0 : ctl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign pc_write   = ctl_o.pc_write;
    assign pc_src     = ctl_o.pc_src;
    assign ir_write   = ctl_o.ir_write;
    assign iord       = ctl_o.iord;
    assign mem_read   = ctl_o.mem_read;
    assign mem_write  = ctl_o.mem_write;
    assign reg_write  = ctl_o.reg_write;
    assign reg_dst    = ctl_o.reg_dst;
    assign mem_to_reg = ctl_o.mem_to_reg;
    assign alu_src_a  = ctl_o.alu_src_a;
    assign alu_src_b  = ctl_o.alu_src_b;
    assign alu_ctl    = ctl_o.alu_ctl;
    assign retire     = ctl_o.retire;
    assign trap       = ctl_o.trap;
    assign state_o    = rst ? S_FETCH : state_q;

`ifdef MIPS_MC_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;

    always_comb begin
        cyc_d = cyc_q;
        ins_d = ins_q;
        if (!ctl.trap) begin
            cyc_d = cyc_q + 1'b1;
            if (ctl.retire) ins_d = ins_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

    assign cyc_cnt = cyc_q;
    assign ins_cnt = ins_q;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl (TIMEOUT overridden to 4).
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;
    logic        pc_write, ir_write, iord, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a, retire, trap;
    logic [1:0]  pc_src, alu_src_b;
    logic [3:0]  alu_ctl, state_o;
`ifdef MIPS_MC_PERF_CNT_EN
    logic [31:0] cyc_cnt, ins_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.OPW(6), .FNW(6), .TIMEOUT(4), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctl    (alu_ctl),
        .retire     (retire),
        .trap       (trap),
`ifdef MIPS_MC_PERF_CNT_EN
        .cyc_cnt    (cyc_cnt),
        .ins_cnt    (ins_cnt),
`endif
        .state_o    (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock edge, then settle before inputs change or checks run
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [3:0] ctl_tab [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b1;
        tick();
        tick();
        chk("rst_state", state_o, 4'd0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_pc_write", pc_write, 1'b0);
        chk("rst_trap", trap, 1'b0);
        rst = 1'b0;
        #1;

        // R-type add, single-cycle memory
        opcode = 6'b000000; funct = 6'b100000;
        chk("f_state", state_o, 4'd0);
        chk("f_mem_read", mem_read, 1'b1);
        chk("f_ir_write", ir_write, 1'b1);
        chk("f_pc_write", pc_write, 1'b1);
        chk("f_srcb", alu_src_b, 2'b01);
        chk("f_alu", alu_ctl, 4'b0010);
        tick();
        chk("d_state", state_o, 4'd1);
        chk("d_srcb", alu_src_b, 2'b11);
        chk("d_mem_read", mem_read, 1'b0);
        tick();
        chk("er_state", state_o, 4'd2);
        chk("er_alu", alu_ctl, 4'b0010);
        chk("er_srca", alu_src_a, 1'b1);
        chk("er_srcb", alu_src_b, 2'b00);
        tick();
        chk("wbr_state", state_o, 4'd3);
        chk("wbr_reg_write", reg_write, 1'b1);
        chk("wbr_reg_dst", reg_dst, 1'b1);
        chk("wbr_retire", retire, 1'b1);
        tick();
        chk("r_back_fetch", state_o, 4'd0);
        chk("r_retire_low", retire, 1'b0);

        // remaining R-type functs
        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            tick();
            tick();
            chk("fn_alu", alu_ctl, ctl_tab[i]);
            tick();
            tick();
        end

        // LW with 3 stall cycles in MEM_RD
        opcode = 6'b100011;
        tick();
        tick();
        chk("lw_exec_i", state_o, 4'd4);
        chk("lw_srcb", alu_src_b, 2'b10);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_stall_state", state_o, 4'd6);
            chk("lw_stall_mem_read", mem_read, 1'b1);
            chk("lw_stall_iord", iord, 1'b1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_ready_mem_read", mem_read, 1'b1);
        chk("lw_ready_state", state_o, 4'd6);
        tick();
        chk("wbm_state", state_o, 4'd7);
        chk("wbm_mem_to_reg", mem_to_reg, 1'b1);
        chk("wbm_reg_write", reg_write, 1'b1);
        chk("wbm_reg_dst", reg_dst, 1'b0);
        tick();
        chk("lw_back_fetch", state_o, 4'd0);

        // SW single-cycle memory
        opcode = 6'b101011;
        tick();
        tick();
        tick();
        chk("sw_state", state_o, 4'd8);
        chk("sw_mem_write", mem_write, 1'b1);
        chk("sw_retire", retire, 1'b1);
        tick();
        chk("sw_back_fetch", state_o, 4'd0);

        // BEQ taken then not taken
        opcode = 6'b000100; alu_zero = 1'b1;
        tick();
        tick();
        chk("beq1_state", state_o, 4'd9);
        chk("beq1_pc_write", pc_write, 1'b1);
        chk("beq1_pc_src", pc_src, 2'b01);
        chk("beq1_alu", alu_ctl, 4'b0110);
        tick();
        chk("beq1_fetch", state_o, 4'd0);
        alu_zero = 1'b0;
        tick();
        tick();
        chk("beq0_pc_write", pc_write, 1'b0);
        chk("beq0_retire", retire, 1'b1);
        tick();
        chk("beq0_fetch", state_o, 4'd0);

        // J
        opcode = 6'b000010;
        tick();
        tick();
        chk("j_state", state_o, 4'd10);
        chk("j_pc_src", pc_src, 2'b10);
        chk("j_pc_write", pc_write, 1'b1);
        tick();

        // fetch timeout: trap after exactly 4 waiting cycles
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_state", state_o, 4'd0);
            chk("to_wait_ir_write", ir_write, 1'b0);
            chk("to_wait_trap", trap, 1'b0);
            tick();
        end
        chk("to_trap", trap, 1'b1);
        chk("to_state", state_o, 4'd15);
        mem_ready = 1'b1;
        tick();
        tick();
        chk("to_sticky", trap, 1'b1);
        chk("to_no_read", mem_read, 1'b0);
        chk("to_no_pcw", pc_write, 1'b0);
        rst = 1'b1;
        #1;
        chk("to_rst_trap", trap, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("to_rst_state", state_o, 4'd0);

        // illegal opcode
        opcode = 6'b111111;
        tick();
        chk("illop_rw", reg_write, 1'b0);
        tick();
        chk("illop_trap", trap, 1'b1);
        chk("illop_rw2", reg_write, 1'b0);
        do_reset();

        // illegal funct
        opcode = 6'b000000; funct = 6'b000001;
        tick();
        tick();
        chk("illfn_state", state_o, 4'd2);
        tick();
        chk("illfn_trap", trap, 1'b1);
        chk("illfn_rw", reg_write, 1'b0);
        do_reset();

        // reset during a pending write
        opcode = 6'b101011;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("mr_mem_write", mem_write, 1'b1);
        rst = 1'b1;
        #1;
        chk("mr_gated", mem_write, 1'b0);
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("mr_state", state_o, 4'd0);

`ifdef MIPS_MC_PERF_CNT_EN
        do_reset();
        chk("pc_cyc_rst", cyc_cnt, 32'd0);
        opcode = 6'b001000;
        for (int i = 0; i < 40; i++) tick();
        chk("pc_ins", ins_cnt, 32'd10);
        chk("pc_cyc", cyc_cnt, 32'd40);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
